// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: receive-side bundle of uart_rx_cfg.
// master drives data/strobe/flags/busy; slave observes them.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_RX_Data;
  logic                 o_DV;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Break;
  logic                 o_Busy;

  modport master (
    output o_RX_Data,
    output o_DV,
    output o_Parity_Err,
    output o_Frame_Err,
    output o_Break,
    output o_Busy
  );

  modport slave (
    input o_RX_Data,
    input o_DV,
    input o_Parity_Err,
    input o_Frame_Err,
    input o_Break,
    input o_Busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5-9 data, parity, 1/2 stop).
// Ports: i_Clock, i_Rst_L (async low), i_RX_Serial (raw pin), rx (bundle).
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          i_Clock,
  input  logic          i_Rst_L,
  input  logic          i_RX_Serial,
  uart_rx_cfg_if.master rx
);

  localparam int   CW   = $clog2(CLKS_PER_BIT);
  localparam int   IW   = $clog2(DATA_BITS + 1);
  localparam int   HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic PEXP = (PARITY == 1) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR,
    S_STOP, S_DONE, S_WAIT
  } state_t;

  state_t st_q, nxt;

  logic                 sync1, rx_s;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] data_q;
  logic                 any_q, frm_q, perr_q;
  logic [DATA_BITS-1:0] out_data;
  logic                 dv_q, out_pe, out_fe, out_brk;
  logic                 full, mid, smp;
  logic                 last_data, last_stop;

  assign full      = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign mid       = (cnt_q == CW'(HALF));
  assign last_data = (bit_idx == IW'(DATA_BITS - 1));
  assign last_stop = (bit_idx == IW'(STOP_BITS - 1));
  assign smp       = full && (st_q == S_DATA ||
                              st_q == S_PAR  ||
                              st_q == S_STOP);

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= i_RX_Serial;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) st_q <= S_IDLE;
    else          st_q <= nxt;
  end

  always_comb begin
    nxt = st_q;
    unique case (st_q)
      S_IDLE:  if (!rx_s) nxt = S_START;
      S_START: if (mid) nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (full && last_data)
                 nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (full) nxt = S_STOP;
      S_STOP:  if (full && last_stop) nxt = S_DONE;
      // a bad stop means the line may still be low
      S_DONE:  nxt = frm_q ? S_WAIT : S_IDLE;
      S_WAIT:  if (rx_s) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q    <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
      any_q    <= 1'b0;
      frm_q    <= 1'b0;
      perr_q   <= 1'b0;
      out_data <= '0;
      dv_q     <= 1'b0;
      out_pe   <= 1'b0;
      out_fe   <= 1'b0;
      out_brk  <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (nxt != st_q || full) cnt_q <= '0;
      else                     cnt_q <= cnt_q + CW'(1);
      if (nxt != st_q)
        bit_idx <= '0;
      else if (full && (st_q == S_DATA || st_q == S_STOP))
        bit_idx <= bit_idx + IW'(1);
      if (st_q == S_START) begin
        any_q  <= 1'b0;
        frm_q  <= 1'b0;
        perr_q <= 1'b0;
      end
      if (smp) begin
        if (rx_s) any_q <= 1'b1;
        // LSB arrives first, so shift in from the top
        if (st_q == S_DATA)
          data_q <= {rx_s, data_q[DATA_BITS-1:1]};
        if (st_q == S_PAR)
          perr_q <= ((^data_q) ^ rx_s) != PEXP;
        if (st_q == S_STOP && !rx_s)
          frm_q <= 1'b1;
      end
      // publish on the last stop sample so data and
      // flags line up with the strobe during DONE
      if (st_q == S_STOP && nxt == S_DONE) begin
        dv_q     <= 1'b1;
        out_data <= data_q;
        out_pe   <= perr_q;
        out_fe   <= frm_q | ~rx_s;
        out_brk  <= ~(any_q | rx_s);
      end
    end
  end

  assign rx.o_RX_Data    = out_data;
  assign rx.o_DV         = dv_q;
  assign rx.o_Parity_Err = out_pe;
  assign rx.o_Frame_Err  = out_fe;
  assign rx.o_Break      = out_brk;
  assign rx.o_Busy       = (st_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed + random frames on four receiver configs.
// Expected frames come from a bit-level model of the serial format.
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_line [4];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int nb_t [4] = '{8, 8, 8, 9};
  int pm_t [4] = '{0, 2, 1, 0};
  int sb_t [4] = '{1, 1, 1, 2};

  typedef struct {
    int         u;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
    int         t;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_rx_cfg_if #(.DATA_BITS(9)) if3 ();

  uart_rx_cfg #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1)
  ) u0 (
    .i_Clock(clk), .i_Rst_L(rst_n),
    .i_RX_Serial(rx_line[0]), .rx(if0.master)
  );
  uart_rx_cfg #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1)
  ) u1 (
    .i_Clock(clk), .i_Rst_L(rst_n),
    .i_RX_Serial(rx_line[1]), .rx(if1.master)
  );
  uart_rx_cfg #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1)
  ) u2 (
    .i_Clock(clk), .i_Rst_L(rst_n),
    .i_RX_Serial(rx_line[2]), .rx(if2.master)
  );
  uart_rx_cfg #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(9),
    .PARITY(0), .STOP_BITS(2)
  ) u3 (
    .i_Clock(clk), .i_Rst_L(rst_n),
    .i_RX_Serial(rx_line[3]), .rx(if3.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if0.o_DV)
      obs_q.push_back('{0, {1'b0, if0.o_RX_Data}, if0.o_Parity_Err,
                        if0.o_Frame_Err, if0.o_Break, cyc});
    if (if1.o_DV)
      obs_q.push_back('{1, {1'b0, if1.o_RX_Data}, if1.o_Parity_Err,
                        if1.o_Frame_Err, if1.o_Break, cyc});
    if (if2.o_DV)
      obs_q.push_back('{2, {1'b0, if2.o_RX_Data}, if2.o_Parity_Err,
                        if2.o_Frame_Err, if2.o_Break, cyc});
    if (if3.o_DV)
      obs_q.push_back('{3, if3.o_RX_Data, if3.o_Parity_Err,
                        if3.o_Frame_Err, if3.o_Break, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic int lat(input int u);
    return 4 + (CPB - 1) / 2 +
           (nb_t[u] + ((pm_t[u] != 0) ? 1 : 0) + sb_t[u]) * CPB;
  endfunction

  task automatic bit_out(input int u, input logic b);
    rx_line[u] = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int u, input int g);
    rx_line[u] = 1'b1;
    if (g > 0) begin
      repeat (g) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int u, input logic [8:0] d,
                            input bit bad, input logic [1:0] st);
    logic [8:0] dm;
    logic       p;
    ev_t        e;
    dm = '0;
    for (int i = 0; i < nb_t[u]; i++) dm[i] = d[i];
    p = (^dm) ^ (pm_t[u] == 1);
    if (bad) p = ~p;
    e.u   = u;
    e.d   = dm;
    e.pe  = bad && (pm_t[u] != 0);
    e.fe  = (st[0] == 1'b0) || (sb_t[u] == 2 && st[1] == 1'b0);
    e.brk = (dm == 0) && (pm_t[u] == 0 || p == 1'b0) &&
            (st[0] == 1'b0) && (sb_t[u] == 1 || st[1] == 1'b0);
    e.t   = cyc;
    exp_q.push_back(e);
    bit_out(u, 1'b0);
    for (int i = 0; i < nb_t[u]; i++) bit_out(u, dm[i]);
    if (pm_t[u] != 0) bit_out(u, p);
    for (int i = 0; i < sb_t[u]; i++) bit_out(u, st[i]);
  endtask

  task automatic drain(input string tag);
    int  n;
    int  k;
    int  dl;
    ev_t o;
    ev_t e;
    n = exp_q.size();
    k = 0;
    while (obs_q.size() < n && k < 4000) begin
      @(posedge clk);
      k++;
    end
    repeat (CPB) @(posedge clk);
    #1;
    chk($sformatf("%s_count", tag), obs_q.size(), n);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk($sformatf("%s_unit", tag), o.u, e.u);
      chk($sformatf("%s_data", tag), o.d, e.d);
      chk($sformatf("%s_perr", tag), o.pe, e.pe);
      chk($sformatf("%s_ferr", tag), o.fe, e.fe);
      chk($sformatf("%s_brk", tag), o.brk, e.brk);
      dl = o.t - e.t - lat(e.u);
      checks++;
      assert (dl >= -1 && dl <= 1) else begin
        errors++;
        $error("FAIL %s_lat got %0d want %0d",
               tag, o.t - e.t, lat(e.u));
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rx_line[i] = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", if0.o_RX_Data, 0);
    chk("rst_dv", if0.o_DV, 0);
    chk("rst_perr", if1.o_Parity_Err, 0);
    chk("rst_ferr", if0.o_Frame_Err, 0);
    chk("rst_brk", if0.o_Break, 0);
    chk("rst_busy", if0.o_Busy, 0);
    chk("rst_data9", if3.o_RX_Data, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    send_frame(0, 9'h037, 1'b0, 2'b11);
    drain("basic");

    send_frame(1, 9'h056, 1'b0, 2'b11);
    send_frame(1, 9'h056, 1'b1, 2'b11);
    drain("even");
    send_frame(2, 9'h056, 1'b0, 2'b11);
    send_frame(2, 9'h056, 1'b1, 2'b11);
    drain("odd");

    rx_line[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("glitch_busy_hi", if0.o_Busy, 1);
    rx_line[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("glitch_busy_lo", if0.o_Busy, 0);
    drain("glitch");
    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    drain("after_glitch");

    send_frame(0, 9'h000, 1'b0, 2'b00);
    repeat (3 * CPB) @(posedge clk);
    #1;
    idle(0, 2 * CPB);
    send_frame(0, 9'h03C, 1'b0, 2'b11);
    drain("break");

    bit_out(0, 1'b0);
    for (int i = 0; i < 4; i++) bit_out(0, 1'b0);
    rx_line[0] = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    chk("mid_busy", if0.o_Busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_data", if0.o_RX_Data, 0);
    chk("arst_dv", if0.o_DV, 0);
    chk("arst_ferr", if0.o_Frame_Err, 0);
    chk("arst_brk", if0.o_Break, 0);
    chk("arst_busy", if0.o_Busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5 * CPB) @(posedge clk);
    #1;
    send_frame(0, 9'h0C3, 1'b0, 2'b11);
    drain("reset");

    send_frame(3, 9'h1FF, 1'b0, 2'b11);
    send_frame(3, 9'h100, 1'b0, 2'b11);
    send_frame(3, 9'h001, 1'b0, 2'b11);
    send_frame(3, 9'h0AA, 1'b0, 2'b01);
    idle(3, CPB);
    drain("b2b");

    for (int u = 0; u < 4; u++) begin
      for (int f = 0; f < 6; f++) begin
        logic [8:0] d;
        bit         bad;
        logic [1:0] st;
        int         g;
        d   = 9'($urandom);
        bad = ($urandom_range(0, 3) == 0);
        st  = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
        send_frame(u, d, bad, st);
        g = $urandom_range(0, CPB);
        if (st[sb_t[u] - 1] == 1'b0) g = CPB;
        idle(u, g);
      end
      drain($sformatf("rand%0d", u));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
